// File: rtl/bgr_sweep_ctrl.sv
// Clocked sequencer for the BGR macro array and its analog output muxes:
// break-before-make switching, porst pulse, settle wait and sampled dwell per channel.
module bgr_sweep_ctrl #(
  parameter int N_BGR      = 32,
  parameter int SEL_W      = 5,
  parameter int N_OUT      = 3,
  parameter int PORST_CYC  = 16,
  parameter int SETTLE_CYC = 64,
  parameter int BBM_CYC    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [SEL_W-1:0]       chan_sel,
  input  logic [N_OUT-1:0]       out_mask,
  input  logic [CNT_W-1:0]       dwell,
  output logic [N_BGR-1:0]       porst,
  output logic [N_OUT*SEL_W-1:0] s_sel,
  output logic [N_OUT-1:0]       decoder_en,
  output logic [N_OUT-1:0]       switch_en,
  output logic                   busy,
  output logic [SEL_W-1:0]       chan_cur,
  output logic                   sample_vld,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_SELECT,
    S_SETTLE,
    S_CONNECT
  } state_t;

  localparam logic [1:0]       MODE_SINGLE = 2'd0;
  localparam logic [1:0]       MODE_SWEEP  = 2'd1;
  localparam logic [CNT_W-1:0] BBM_LAST    = CNT_W'(BBM_CYC - 1);
  localparam logic [CNT_W-1:0] PORST_LAST  = CNT_W'(PORST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] CHAN_LAST   = SEL_W'(N_BGR - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] dwell_reg;
  logic [1:0]       mode_reg;
  logic [N_OUT-1:0] mask_reg;
  logic [SEL_W-1:0] chan_cur_reg;
  logic [SEL_W-1:0] sel_reg;
  logic             abort_pend_reg;
  logic [N_BGR-1:0] porst_reg;
  logic [N_OUT-1:0] decoder_en_reg;
  logic [N_OUT-1:0] switch_en_reg;
  logic             busy_reg;
  logic             sample_vld_reg;
  logic             done_reg;
  logic             err_reg;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] dwell_last;
  logic             start_ok;
  logic             last_chan;
  logic [SEL_W-1:0] chan_next;
  logic [N_BGR-1:0] porst_onehot;

  // Saturating phase counter; it is cleared on every phase change anyway.
  assign cnt_inc      = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
  assign dwell_last   = (dwell_reg == '0) ? '0 : dwell_reg - 1'b1;
  assign start_ok     = (mode != 2'd3) && ({1'b0, chan_sel} < (SEL_W + 1)'(N_BGR));
  assign last_chan    = (chan_cur_reg == CHAN_LAST);
  assign chan_next    = last_chan ? '0 : chan_cur_reg + 1'b1;
  assign porst_onehot = N_BGR'(1) << chan_cur_reg;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      dwell_reg      <= '0;
      mode_reg       <= '0;
      mask_reg       <= '0;
      chan_cur_reg   <= '0;
      sel_reg        <= '0;
      abort_pend_reg <= 1'b0;
      porst_reg      <= '0;
      decoder_en_reg <= '0;
      switch_en_reg  <= '0;
      busy_reg       <= 1'b0;
      sample_vld_reg <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      done_reg       <= 1'b0;
      sample_vld_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // abort together with start cancels the request silently
          if (start && !abort) begin
            if (start_ok) begin
              state_reg      <= S_BREAK;
              cnt_reg        <= '0;
              mode_reg       <= mode;
              mask_reg       <= out_mask;
              dwell_reg      <= dwell;
              chan_cur_reg   <= chan_sel;
              abort_pend_reg <= 1'b0;
              busy_reg       <= 1'b1;
              err_reg        <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (cnt_reg == BBM_LAST) begin
            cnt_reg <= '0;
            if (abort || abort_pend_reg) begin
              state_reg      <= S_IDLE;
              abort_pend_reg <= 1'b0;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
            end else begin
              state_reg      <= S_SELECT;
              sel_reg        <= chan_cur_reg;
              decoder_en_reg <= mask_reg;
              porst_reg      <= porst_onehot;
            end
          end else begin
            cnt_reg <= cnt_inc;
            if (abort) abort_pend_reg <= 1'b1;
          end
        end
        default: begin
          if (abort) begin
            // Open everything and run a full gap before returning to IDLE.
            state_reg      <= S_BREAK;
            cnt_reg        <= '0;
            abort_pend_reg <= 1'b1;
            porst_reg      <= '0;
            decoder_en_reg <= '0;
            switch_en_reg  <= '0;
          end else if (state_reg == S_SELECT) begin
            if (cnt_reg == PORST_LAST) begin
              state_reg <= S_SETTLE;
              cnt_reg   <= '0;
              porst_reg <= '0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end else if (state_reg == S_SETTLE) begin
            if (cnt_reg == SETTLE_LAST) begin
              state_reg      <= S_CONNECT;
              cnt_reg        <= '0;
              switch_en_reg  <= mask_reg;
              sample_vld_reg <= (dwell_last == '0);
            end else begin
              cnt_reg <= cnt_inc;
            end
          end else begin
            if (cnt_reg == dwell_last) begin
              cnt_reg        <= '0;
              switch_en_reg  <= '0;
              decoder_en_reg <= '0;
              if (mode_reg == MODE_SINGLE || (mode_reg == MODE_SWEEP && last_chan)) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                state_reg    <= S_BREAK;
                chan_cur_reg <= chan_next;
              end
            end else begin
              cnt_reg        <= cnt_inc;
              sample_vld_reg <= (cnt_inc == dwell_last);
            end
          end
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_sel
      assign s_sel[gi*SEL_W +: SEL_W] = sel_reg;
    end
  endgenerate

  assign porst      = porst_reg;
  assign decoder_en = decoder_en_reg;
  assign switch_en  = switch_en_reg;
  assign busy       = busy_reg;
  assign chan_cur   = chan_cur_reg;
  assign sample_vld = sample_vld_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_bgr_sweep_ctrl.sv
// Directed bench for bgr_sweep_ctrl: per-cycle statistics gathered by tick(),
// checked against hand-computed phase lengths (BBM 4, PORST 16, SETTLE 64).
module tb_bgr_sweep_ctrl;
  localparam int N_BGR = 32;
  localparam int SEL_W = 6;
  localparam int N_OUT = 3;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   abort;
  logic [1:0]             mode;
  logic [SEL_W-1:0]       chan_sel;
  logic [N_OUT-1:0]       out_mask;
  logic [CNT_W-1:0]       dwell;
  logic [N_BGR-1:0]       porst;
  logic [N_OUT*SEL_W-1:0] s_sel;
  logic [N_OUT-1:0]       decoder_en;
  logic [N_OUT-1:0]       switch_en;
  logic                   busy;
  logic [SEL_W-1:0]       chan_cur;
  logic                   sample_vld;
  logic                   done;
  logic                   err;

  always #5 clk = ~clk;

  bgr_sweep_ctrl #(
    .N_BGR(N_BGR), .SEL_W(SEL_W), .N_OUT(N_OUT), .PORST_CYC(16),
    .SETTLE_CYC(64), .BBM_CYC(4), .CNT_W(CNT_W)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort), .mode(mode),
    .chan_sel(chan_sel), .out_mask(out_mask), .dwell(dwell), .porst(porst),
    .s_sel(s_sel), .decoder_en(decoder_en), .switch_en(switch_en), .busy(busy),
    .chan_cur(chan_cur), .sample_vld(sample_vld), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int busy_cnt, porst_cnt, sw_cnt, dec_cnt, sample_cnt, sample_at, done_cnt, inv_err;
  logic [N_BGR-1:0]       porst_seen;
  logic [N_OUT-1:0]       sw_seen;
  logic [N_OUT*SEL_W-1:0] prev_ssel;
  logic [SEL_W-1:0]       chans[$];

  function automatic logic [N_OUT*SEL_W-1:0] rep(input logic [SEL_W-1:0] c);
    return {N_OUT{c}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; porst_cnt = 0; sw_cnt = 0; dec_cnt = 0; sample_cnt = 0;
    sample_at = 0; done_cnt = 0; inv_err = 0; porst_seen = '0; sw_seen = '0;
    prev_ssel = s_sel;
    chans.delete();
  endtask

  // One clock; sample #1 after the edge and accumulate statistics.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (porst != '0) begin
      porst_cnt++;
      porst_seen |= porst;
      if ($countones(porst) != 1) inv_err++;
    end
    if (switch_en != '0) begin
      sw_cnt++;
      sw_seen |= switch_en;
      if (porst != '0) inv_err++;
      if (s_sel != prev_ssel) inv_err++;
    end
    if (decoder_en != '0) dec_cnt++;
    if (sample_vld) begin
      sample_cnt++;
      sample_at = busy_cnt;
      chans.push_back(chan_cur);
    end
    if (done) done_cnt++;
    prev_ssel = s_sel;
  endtask

  task automatic launch(input logic [1:0] m, input logic [SEL_W-1:0] c,
                        input logic [N_OUT-1:0] msk, input logic [CNT_W-1:0] d);
    clear_stats();
    mode = m; chan_sel = c; out_mask = msk; dwell = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  task automatic run_until_busy(input string tag, input int target);
    int n = 0;
    while (busy_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 64'(busy_cnt), 64'(target));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; chan_sel = '0;
    out_mask = '0; dwell = '0;
    repeat (3) tick();
    chk("reset_ctrl", 64'({porst, switch_en, decoder_en, busy, done, sample_vld, err}), 64'(0));
    chk("reset_sel", 64'({s_sel, chan_cur}), 64'(0));
    rst = 1'b0;
    tick();

    // T1 single channel 7, dwell 10
    launch(2'd0, 6'd7, 3'b111, 16'd10);
    chk("t1_busy_break", 64'({busy, switch_en, decoder_en}), 64'({1'b1, 3'b000, 3'b000}));
    run_until_done("t1_done", 200);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'(94));
    chk("t1_porst_cycles", 64'(porst_cnt), 64'(16));
    chk("t1_porst_bits", 64'(porst_seen), 64'(32'h0000_0080));
    chk("t1_switch_cycles", 64'(sw_cnt), 64'(10));
    chk("t1_switch_val", 64'(sw_seen), 64'(3'b111));
    chk("t1_decoder_cycles", 64'(dec_cnt), 64'(90));
    chk("t1_samples", 64'(sample_cnt), 64'(1));
    chk("t1_sample_at", 64'(sample_at), 64'(94));
    chk("t1_sample_chan", 64'(chans[0]), 64'(7));
    chk("t1_ssel", 64'(s_sel), 64'(rep(6'd7)));
    chk("t1_invariants", 64'(inv_err), 64'(0));
    tick();
    chk("t1_done_pulse", 64'({done, busy}), 64'(0));
    $display("T1 single ch7: busy=%0d samples=%0d", busy_cnt, sample_cnt);

    // T2 sweep once from 30
    launch(2'd1, 6'd30, 3'b101, 16'd1);
    run_until_done("t2_done", 400);
    chk("t2_busy_cycles", 64'(busy_cnt), 64'(170));
    chk("t2_samples", 64'(sample_cnt), 64'(2));
    chk("t2_chan0", 64'(chans[0]), 64'(30));
    chk("t2_chan1", 64'(chans[1]), 64'(31));
    chk("t2_porst_bits", 64'(porst_seen), 64'(32'hC000_0000));
    chk("t2_switch", 64'({sw_cnt[7:0], 5'b0, sw_seen}), 64'({8'd2, 5'b0, 3'b101}));
    chk("t2_decoder_cycles", 64'(dec_cnt), 64'(162));
    chk("t2_done_cnt", 64'(done_cnt), 64'(1));
    chk("t2_ssel", 64'(s_sel), 64'(rep(6'd31)));
    chk("t2_invariants", 64'(inv_err), 64'(0));
    $display("T2 sweep 30..31: busy=%0d samples=%0d", busy_cnt, sample_cnt);

    // T3 continuous from 31, abort mid-SETTLE of channel 1
    launch(2'd2, 6'd31, 3'b011, 16'd3);
    run_until_busy("t3_reach_settle", 220);
    chk("t3_chan_cur", 64'(chan_cur), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort_break", 64'({porst, switch_en, decoder_en, busy}), 64'({32'h0, 3'b000, 3'b000, 1'b1}));
    run_until_done("t3_done", 20);
    chk("t3_busy_cycles", 64'(busy_cnt), 64'(224));
    chk("t3_samples", 64'({sample_cnt[7:0], 2'b0, chans[0], 2'b0, chans[1]}),
        64'({8'd2, 2'b0, 6'd31, 2'b0, 6'd0}));
    chk("t3_invariants", 64'(inv_err), 64'(0));
    $display("T3 continuous abort: busy=%0d samples=%0d", busy_cnt, sample_cnt);

    // T3b abort while porst is high
    launch(2'd0, 6'd9, 3'b111, 16'd5);
    run_until_busy("t3b_reach_select", 10);
    chk("t3b_porst_on", 64'(porst), 64'(32'h0000_0200));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3b_porst_off", 64'({porst, decoder_en}), 64'(0));
    run_until_done("t3b_done", 20);
    chk("t3b_busy_cycles", 64'({busy_cnt[15:0], sample_cnt[15:0], sw_cnt[15:0]}), 64'({16'd14, 16'd0, 16'd0}));

    // abort together with start in IDLE
    tick();
    clear_stats();
    mode = 2'd0; chan_sel = 6'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("abort_start_idle", 64'({busy, done, err, 29'(busy_cnt + done_cnt)}), 64'(0));

    // T4 rejections, then T5 dwell=0 with an ignored start pulse
    launch(2'd3, 6'd4, 3'b111, 16'd1);
    chk("t4_mode3", 64'({err, busy}), 64'(2'b10));
    tick();
    chk("t4_err_sticky", 64'({err, busy}), 64'(2'b10));
    launch(2'd0, 6'd32, 3'b111, 16'd1);
    chk("t4_chan32", 64'({err, busy}), 64'(2'b10));
    launch(2'd0, 6'd5, 3'b110, 16'd0);
    chk("t4_err_cleared", 64'({err, busy}), 64'(2'b01));
    run_until_busy("t5_reach", 30);
    chan_sel = 6'd3; mode = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done("t5_done", 200);
    chk("t5_busy_cycles", 64'(busy_cnt), 64'(85));
    chk("t5_sample", 64'({sample_cnt[7:0], sample_at[7:0], 2'b0, chans[0]}), 64'({8'd1, 8'd85, 2'b0, 6'd5}));
    chk("t5_switch", 64'({sw_cnt[7:0], 5'b0, sw_seen}), 64'({8'd1, 5'b0, 3'b110}));
    chk("t5_err_done", 64'({err, done_cnt[3:0]}), 64'({1'b0, 4'd1}));
    $display("T4/T5 reject and dwell0: busy=%0d samples=%0d", busy_cnt, sample_cnt);

    // T6 reset during CONNECT, then a normal run
    tick();
    launch(2'd0, 6'd2, 3'b011, 16'd20);
    run_until_busy("t6_reach_connect", 90);
    chk("t6_connected", 64'(switch_en), 64'(3'b011));
    rst = 1'b1;
    tick();
    chk("t6_reset_ctrl", 64'({porst, switch_en, decoder_en, busy, done, sample_vld, err}), 64'(0));
    chk("t6_reset_sel", 64'({s_sel, chan_cur}), 64'(0));
    rst = 1'b0;
    tick();
    launch(2'd0, 6'd4, 3'b010, 16'd2);
    run_until_done("t6_done", 200);
    chk("t6_busy_cycles", 64'(busy_cnt), 64'(86));
    chk("t6_sample", 64'({sample_cnt[7:0], 2'b0, chans[0], 5'b0, sw_seen}), 64'({8'd1, 2'b0, 6'd4, 5'b0, 3'b010}));
    chk("t6_invariants", 64'(inv_err), 64'(0));
    $display("T6 reset recovery: busy=%0d samples=%0d", busy_cnt, sample_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
